// File: rtl/fpga_cfg_pkg.sv
// Shared constants, state encoding and width helpers for the configuration loader.
package fpga_cfg_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        HUNT,
        LOAD,
        CHECK,
        COMMIT
    } cfg_state_t;

    function automatic int unsigned brb_bits(input int unsigned fw, input int unsigned ww);
        return fw * ww * 12;
    endfunction

    function automatic int unsigned bsb_bits(input int unsigned fw, input int unsigned ww);
        return (fw - 1) * ww * ww * 12;
    endfunction

    function automatic int unsigned lb_bits(input int unsigned fw);
        return (fw - 1) * 5;
    endfunction

    function automatic int unsigned cfg_bits(input int unsigned fw, input int unsigned ww);
        return brb_bits(fw, ww) + bsb_bits(fw, ww) + lb_bits(fw);
    endfunction

    function automatic int unsigned cfg_bytes(input int unsigned fw, input int unsigned ww);
        return (cfg_bits(fw, ww) + 7) / 8;
    endfunction

endpackage

// File: rtl/fpga_config_loader.sv
// Byte-serial configuration loader: hunts for a sync byte, fills a shadow image,
// verifies an XOR checksum and commits the image to the active select vectors atomically.
module fpga_config_loader
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned wire_width = 3,
    parameter int unsigned fpga_width = 5,
    localparam int unsigned BRB_BITS  = brb_bits(fpga_width, wire_width),
    localparam int unsigned BSB_BITS  = bsb_bits(fpga_width, wire_width),
    localparam int unsigned LB_BITS   = lb_bits(fpga_width)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                abort,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [BRB_BITS-1:0] brbselect,
    output logic [BSB_BITS-1:0] bsbselect,
    output logic [LB_BITS-1:0]  lbselect,
    output logic                cfg_done,
    output logic                cfg_error
);

    localparam int unsigned CFG_BITS  = BRB_BITS + BSB_BITS + LB_BITS;
    localparam int unsigned CFG_BYTES = (CFG_BITS + 7) / 8;
    localparam int unsigned CNT_W     = $clog2(CFG_BYTES) + 1;
    localparam int unsigned IDX_W     = $clog2(CFG_BYTES * 8);

    cfg_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [7:0]          xor_q;
    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [31:0]         base;
    logic [IDX_W-1:0]    bit_idx;
    logic                accept, start, load_en, set_err, commit;

    assign in_ready = rst_n && (state_q != COMMIT);
    assign accept   = in_valid && in_ready;
    assign base     = 32'(cnt_q) << 3;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        load_en = 1'b0;
        set_err = 1'b0;
        commit  = 1'b0;
        case (state_q)
            HUNT: begin
                if (accept && in_data == SYNC_BYTE) begin
                    state_d = LOAD;
                    start   = 1'b1;
                end
            end
            LOAD: begin
                if (accept) begin
                    load_en = 1'b1;
                    if (cnt_q == CNT_W'(CFG_BYTES - 1)) state_d = CHECK;
                end
            end
            CHECK: begin
                if (accept) begin
                    if (in_data == xor_q) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = HUNT;
                        set_err = 1'b1;
                    end
                end
            end
            COMMIT: begin
                state_d = HUNT;
                commit  = 1'b1;
            end
            default: state_d = HUNT;
        endcase
        // Abort wins over everything, including a byte accepted in the same cycle.
        if (abort) begin
            state_d = HUNT;
            start   = 1'b0;
            load_en = 1'b0;
            set_err = 1'b0;
            commit  = 1'b0;
        end
    end

    // Per-bit write so padding bits of the final byte beyond CFG_BITS are dropped.
    always_comb begin
        shadow_d = shadow_q;
        bit_idx  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            bit_idx = IDX_W'(base + i);
            if (base + i < CFG_BITS) shadow_d[bit_idx] = in_data[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            cnt_q     <= '0;
            xor_q     <= '0;
            shadow_q  <= '0;
            brbselect <= '0;
            bsbselect <= '0;
            lbselect  <= '0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                cnt_q     <= '0;
                xor_q     <= '0;
                cfg_done  <= 1'b0;
                cfg_error <= 1'b0;
            end
            if (load_en) begin
                shadow_q <= shadow_d;
                cnt_q    <= cnt_q + CNT_W'(1);
                xor_q    <= xor_q ^ in_data;
            end
            if (set_err) cfg_error <= 1'b1;
            if (commit) begin
                brbselect <= shadow_q[BRB_BITS-1:0];
                bsbselect <= shadow_q[BRB_BITS +: BSB_BITS];
                lbselect  <= shadow_q[BRB_BITS+BSB_BITS +: LB_BITS];
                cfg_done  <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fpga_config_loader.md
FPGA_CONFIG_LOADER -- requirements
Module: fpga_config_loader

Interface
REQ-001 Parameter wire_width, default 3, routing channel width per row segment; SHALL match the configured row.
REQ-002 Parameter fpga_width, default 5, number of columns per row; SHALL match the configured row.
REQ-003 Derived constants: BRB_BITS = fpga_width*wire_width*12; BSB_BITS = (fpga_width-1)*wire_width*wire_width*12; LB_BITS = (fpga_width-1)*5; CFG_BITS = sum of the three (632 at defaults); CFG_BYTES = ceil(CFG_BITS/8) (79 at defaults).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 abort  input  1  synchronous frame abort, active-high.
REQ-007 in_data  input  8  bitstream byte.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 brbselect  output  BRB_BITS  active routing-block configuration.
REQ-011 bsbselect  output  BSB_BITS  active switch-block configuration.
REQ-012 lbselect  output  LB_BITS  active logic-block configuration.
REQ-013 cfg_done  output  1  last frame committed successfully.
REQ-014 cfg_error  output  1  last frame rejected on checksum.

Function
REQ-015 A byte is accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-016 Frame format: sync byte 0xA5, then CFG_BYTES payload bytes, then one checksum byte equal to the XOR of all payload bytes.
REQ-017 FSM states: HUNT, LOAD, CHECK, COMMIT; reset state HUNT.
REQ-018 HUNT: accepted 0xA5 -> LOAD, byte counter cleared, running XOR cleared, cfg_done and cfg_error cleared; any other accepted byte is discarded.
REQ-019 LOAD: each accepted byte is written to shadow bits [8k+7:8k] of the concatenation {lbselect, bsbselect, brbselect} (brbselect LSB-first), where k = byte count; bits at or above CFG_BITS in the last byte are discarded; transition to CHECK after byte CFG_BYTES-1.
REQ-020 CHECK: accepted byte equal to the running XOR -> COMMIT; mismatch -> HUNT with cfg_error=1 and active outputs unchanged.
REQ-021 COMMIT: lasts exactly one cycle with in_ready=0; copies shadow to brbselect/bsbselect/lbselect, sets cfg_done=1, returns to HUNT.
REQ-022 Active outputs change only in COMMIT; they are never partially updated.
REQ-023 in_ready=1 in HUNT, LOAD, CHECK; 0 in COMMIT.
REQ-024 abort=1 in any state -> HUNT next cycle, shadow contents irrelevant, active outputs, cfg_done and cfg_error unchanged; abort has priority over a simultaneously accepted byte, which is dropped.
REQ-025 in_valid gaps of any length in LOAD/CHECK pause the frame without timeout.
REQ-026 cfg_done and cfg_error are mutually exclusive and hold until the next accepted sync byte or reset.
REQ-027 Byte counter width: clog2(CFG_BYTES)+1 bits; no wrap occurs within a frame.

Reset
REQ-028 rst_n=0 asynchronously forces: state HUNT, counter 0, XOR 0, shadow 0, brbselect/bsbselect/lbselect all 0, cfg_done 0, cfg_error 0, in_ready 0 while asserted.
REQ-029 Reset mid-frame discards the partial frame; after release the loader hunts for 0xA5.

Structure
REQ-030 Sync value 0xA5, derived width constants and the state enum SHALL live in shared package fpga_cfg_pkg.
REQ-031 Single module, no sub-module; shadow and active registers are flat vectors.

Verification
REQ-032 Valid frame at defaults, payload bytes 0x00..0x4E, checksum = XOR of those values -> in_ready low for exactly one cycle after the checksum byte, cfg_done=1, brbselect[7:0]=0x00, brbselect[15:8]=0x01.
REQ-033 Same frame with checksum XOR 0x01 -> cfg_error=1, cfg_done=0, outputs keep previous committed values.
REQ-034 Bytes 0x00, 0x5A, 0xFF before 0xA5, then a valid frame -> leading bytes ignored, commit identical to the clean frame.
REQ-035 abort pulsed after payload byte 40 of a frame, then full valid frame -> outputs reflect only the second frame, and no commit occurs between the two frames.
REQ-036 rst_n dropped mid-LOAD -> all outputs 0 immediately (asynchronous); a subsequent valid frame commits normally.
REQ-037 in_valid toggled randomly (50%) across a valid frame -> same final outputs as the back-to-back frame.
